ddr_rd_serializer: RTL and testbench

Read-path counterpart of the UART-to-DDR3 word packer. Accepts one 256-bit DDR3 read beat (eight 32-bit words, word 0 in bits [255:224]) and emits it as 32 bytes to the UART transmitter, in the same order the write path packed them. Sits between the DDR3 read-data port and the UART TX byte interface.

---
 rtl/ddr_rd_serializer_pkg.sv | 15 +
 rtl/ddr_rd_serializer.sv | 88 ++++++++
 tb/tb_ddr_rd_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_serializer_pkg.sv
// Shared beat geometry and FSM encoding for the DDR3 read serializer; the
// defaults match the write-path packer so both ends agree on width and order.
package ddr_rd_serializer_pkg;

  localparam int DEF_NUM_WORDS = 8;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_BEAT_W    = DEF_NUM_WORDS * DEF_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ddr_rd_serializer.sv
// Serializes one DDR3 read beat into bytes for the UART transmitter, MSB byte
// of word 0 first, matching the order the write-path packer assembled them.
//
// state   | meaning
// IDLE    | ready for a beat (once out of reset)
// SEND    | presenting top byte of shift register, shifting on handshake
// DONE    | one-cycle completion pulse
module ddr_rd_serializer
  import ddr_rd_serializer_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WORDS*WORD_W-1:0] i_rd_data,
  input  logic                        i_rd_valid,
  output logic                        o_rd_ready,
  output logic [7:0]                  o_tx_byte,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int N  = NUM_WORDS * WORD_W;
  localparam int NB = N / 8;
  localparam int CW = $clog2(NB) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  sh;
  logic [CW-1:0] cnt;
  logic          rdy_q;
  logic          load, take;

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    take       = 1'b0;
    o_tx_valid = 1'b0;
    o_done     = 1'b0;
    o_busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        // rdy_q gates the load so nothing is captured while ready reads 0
        load = rdy_q & i_rd_valid;
        if (load) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        take       = i_tx_ready;
        if (take && (cnt == LAST)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      rdy_q <= 1'b0;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == ST_IDLE);
      if (load) begin
        sh  <= i_rd_data;
        cnt <= '0;
      end else if (take) begin
        sh  <= {sh[N-9:0], 8'h00};
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_rd_ready = rdy_q;
  assign o_tx_byte  = sh[N-1 -: 8];

endmodule

// File: tb/tb_ddr_rd_serializer.sv
// Directed bench for ddr_rd_serializer: beats are scored into a byte queue on
// acceptance and each UART handshake pops and compares the next byte.
module tb_ddr_rd_serializer;

  localparam int N  = 256;
  localparam int NB = N / 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] i_rd_data;
  logic         i_rd_valid;
  logic         o_rd_ready;
  logic [7:0]   o_tx_byte;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_busy;
  logic         o_done;

  ddr_rd_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .i_rd_data (i_rd_data),
    .i_rd_valid(i_rd_valid),
    .o_rd_ready(o_rd_ready),
    .o_tx_byte (o_tx_byte),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         loads    = 0;
  int         done_cnt = 0;
  int         nbytes   = 0;
  int         cyc_n    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         hs_log[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;
  logic       chk_busy_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat_byte(input logic [N-1:0] b, input int k);
    return b[N-1-8*k -: 8];
  endfunction

  // Model of the write-path packer: byte k lands at [N-1-8k -: 8].
  function automatic logic [N-1:0] pack(input logic [7:0] b[NB]);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) v[N-1-8*k -: 8] = b[k];
    return v;
  endfunction

  task automatic monitor();
    logic [7:0] e;
    if (prev_stall) begin
      chk("stall_valid", 64'(o_tx_valid), 64'd1);
      chk("stall_byte", 64'(o_tx_byte), 64'(prev_byte));
    end
    if (chk_busy_rdy && o_busy === 1'b1) chk("busy_rd_ready", 64'(o_rd_ready), 64'd0);
    if (rst === 1'b1 && o_tx_valid === 1'b1 && i_tx_ready === 1'b1) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_byte: observed %0h expected none", o_tx_byte);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("byte_order", 64'(o_tx_byte), 64'(e));
      end
      rx_log.push_back(o_tx_byte);
      hs_log.push_back(cyc_n);
      nbytes++;
    end
    if (rst === 1'b1 && o_rd_ready === 1'b1 && i_rd_valid === 1'b1) begin
      for (int k = 0; k < NB; k++) exp_q.push_back(beat_byte(i_rd_data, k));
      loads++;
    end
    if (o_done === 1'b1) done_cnt++;
    prev_stall = (rst === 1'b1) && (o_tx_valid === 1'b1) && (i_tx_ready === 1'b0);
    prev_byte  = o_tx_byte;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic load_beat(input logic [N-1:0] d, input string tag);
    int l0;
    int c;
    l0 = loads;
    c  = 0;
    i_rd_data  = d;
    i_rd_valid = 1'b1;
    while (loads == l0 && c < 50) begin
      cyc();
      c++;
    end
    i_rd_valid = 1'b0;
    chk({tag, "_load"}, 64'(loads - l0), 64'd1);
  endtask

  // mode 0: i_tx_ready held high; mode 1: 1,0,0,1 then random
  task automatic run(input int want_loads, input int want_done, input int mode, input string tag);
    int         c;
    logic [3:0] pat;
    c   = 0;
    pat = 4'b1001;
    while (done_cnt < want_done && c < 600) begin
      if (mode == 1) i_tx_ready = (c < 4) ? pat[c] : 1'($urandom_range(0, 1));
      else           i_tx_ready = 1'b1;
      cyc();
      c++;
      if (loads >= want_loads) i_rd_valid = 1'b0;
    end
    chk({tag, "_done_reached"}, 64'(done_cnt >= want_done), 64'd1);
  endtask

  logic [N-1:0] beat_ord, beat_hi, beat_a, beat_b, beat_rt;
  logic [7:0]   orig[NB];
  int           n0, d0, l0, c;

  initial begin
    for (int k = 0; k < NB; k++) begin
      beat_ord[N-1-8*k -: 8] = 8'(k);
      beat_hi[N-1-8*k -: 8]  = 8'(k + 32);
    end
    beat_a = {NB{8'hAA}};
    beat_b = {NB{8'h55}};

    rst = 1'b0; i_rd_valid = 1'b0; i_rd_data = '0; i_tx_ready = 1'b0;
    cyc(); cyc();
    chk("rst_rd_ready", 64'(o_rd_ready), 64'd0);
    chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_tx_byte", 64'(o_tx_byte), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    rst = 1'b1;
    cyc();
    chk("post_rst_rd_ready", 64'(o_rd_ready), 64'd1);

    // In-order beat with no backpressure, exact cycle timing.
    i_tx_ready = 1'b1;
    n0 = nbytes; d0 = done_cnt;
    load_beat(beat_ord, "order");
    chk("order_first_byte", 64'(o_tx_byte), 64'h00);
    for (int i = 0; i < NB; i++) begin
      chk("order_valid", 64'(o_tx_valid), 64'd1);
      cyc();
    end
    chk("order_done_pulse", 64'(o_done), 64'd1);
    chk("order_done_valid", 64'(o_tx_valid), 64'd0);
    chk("order_done_rdy", 64'(o_rd_ready), 64'd0);
    cyc();
    chk("order_done_width", 64'(o_done), 64'd0);
    chk("order_rdy_back", 64'(o_rd_ready), 64'd1);
    chk("order_busy", 64'(o_busy), 64'd0);
    chk("order_nbytes", 64'(nbytes - n0), 64'd32);
    chk("order_ndone", 64'(done_cnt - d0), 64'd1);

    // Backpressure.
    n0 = nbytes; d0 = done_cnt;
    load_beat(beat_ord, "bp");
    run(loads, d0 + 1, 1, "bp");
    chk("bp_nbytes", 64'(nbytes - n0), 64'd32);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Beat offered while busy must wait for the next IDLE.
    n0 = nbytes; d0 = done_cnt;
    load_beat(beat_ord, "busy");
    l0 = loads;
    i_rd_data = '1;
    i_rd_valid = 1'b1;
    chk_busy_rdy = 1'b1;
    run(l0 + 1, d0 + 2, 0, "busy");
    chk_busy_rdy = 1'b0;
    chk("busy_loads", 64'(loads - l0), 64'd1);
    chk("busy_nbytes", 64'(nbytes - n0), 64'd64);
    chk("busy_last_ff", 64'(rx_log[rx_log.size()-1]), 64'hFF);

    // Reset after byte 10 is accepted.
    n0 = nbytes;
    load_beat(beat_ord, "mid");
    i_tx_ready = 1'b1;
    c = 0;
    while (nbytes < n0 + 11 && c < 100) begin
      cyc();
      c++;
    end
    chk("mid_bytes_before_rst", 64'(nbytes - n0), 64'd11);
    rst = 1'b0;
    cyc();
    chk("mid_rst_valid", 64'(o_tx_valid), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_rdy", 64'(o_rd_ready), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    cyc();
    chk("mid_rdy_after", 64'(o_rd_ready), 64'd1);
    d0 = done_cnt;
    load_beat(beat_hi, "mid2");
    chk("mid_restart_byte0", 64'(o_tx_byte), 64'h20);
    run(loads, d0 + 1, 0, "mid2");

    // Back-to-back beats with i_rd_valid held.
    cyc();
    hs_log.delete(); rx_log.delete();
    d0 = done_cnt; l0 = loads;
    i_rd_data = beat_a;
    i_rd_valid = 1'b1;
    c = 0;
    while (loads == l0 && c < 20) begin
      cyc();
      c++;
    end
    i_rd_data = beat_b;
    run(l0 + 2, d0 + 2, 0, "b2b");
    chk("b2b_nbytes", 64'(hs_log.size()), 64'd64);
    chk("b2b_gap", 64'((hs_log.size() > 32) ? hs_log[32] - hs_log[31] : -1), 64'd3);
    chk("b2b_ndone", 64'(done_cnt - d0), 64'd2);
    chk("b2b_b_first", 64'((rx_log.size() > 32) ? rx_log[32] : 8'h00), 64'h55);

    // Round trip through the packer model.
    cyc();
    for (int k = 0; k < NB; k++) orig[k] = 8'($urandom_range(0, 255));
    beat_rt = pack(orig);
    rx_log.delete();
    d0 = done_cnt;
    load_beat(beat_rt, "rt");
    run(loads, d0 + 1, 1, "rt");
    chk("rt_len", 64'(rx_log.size()), 64'd32);
    for (int k = 0; k < NB; k++)
      chk("rt_byte", 64'((rx_log.size() > k) ? rx_log[k] : ~orig[k]), 64'(orig[k]));

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
